// File: rtl/rv_pkg.sv
// Shared RV64 encoding constants: instruction format codes used by imm_enc.
package rv_pkg;
  localparam logic [2:0] I_TYPE = 3'd0;
  localparam logic [2:0] S_TYPE = 3'd1;
  localparam logic [2:0] B_TYPE = 3'd2;
  localparam logic [2:0] U_TYPE = 3'd3;
  localparam logic [2:0] J_TYPE = 3'd4;
  localparam logic [2:0] FMT_LI = 3'd7;
endpackage

// File: rtl/imm_enc_if.sv
// Request/response handshake bundle between the program sequencer and imm_enc.
interface imm_enc_if;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_fmt;
  logic [6:0]  i_opcode;
  logic [4:0]  i_rd;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic [2:0]  i_funct3;
  logic [63:0] i_imm;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic        o_last;
  logic        o_err;

  modport slave (
    input  i_valid, i_fmt, i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_imm, i_ready,
    output o_ready, o_valid, o_instr, o_last, o_err
  );

  modport master (
    output i_valid, i_fmt, i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_imm, i_ready,
    input  o_ready, o_valid, o_instr, o_last, o_err
  );
endinterface

// File: rtl/imm_enc.sv
// RV64 instruction encoder: packs fields + immediate into 32-bit words, expands li.
// Optional macro IMM_ENC_RANGE_CHECK_EN enables immediate range checking on o_err.
module imm_enc
  import rv_pkg::*;
(
  input logic       i_clk,
  input logic       i_rst,
  imm_enc_if.slave  bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_LI_LO = 1'b1;

  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_IMM32 = 7'h1B;

  logic [0:0]  state_r;
  logic        valid_r;
  logic [31:0] instr_r;
  logic        last_r;
  logic        err_r;
  logic [31:0] pend_instr_r;
  logic        pend_err_r;

  logic [31:0] word_s;
  logic [31:0] pend_s;
  logic        two_s;
  logic        chk_err_s;
  logic        ready_s;
  logic        accept_s;
  logic [19:0] li_hi_s;
  logic [11:0] li_lo_s;
  logic [63:0] imm_s;

  assign imm_s = bus.i_imm;

  // Rounding by +0x800 only carries into bit 12 when imm[11] is set.
  assign li_hi_s = imm_s[31:12] + {19'd0, imm_s[11]};
  assign li_lo_s = imm_s[11:0];

`ifdef IMM_ENC_RANGE_CHECK_EN
  function automatic logic fits_signed(input logic [63:0] v, input int unsigned w);
    logic [63:0] t;
    t = $signed(v) >>> (w - 32'd1);
    return (t == 64'd0) || (t == {64{1'b1}});
  endfunction

  // Immediate legality per format; a set bit marks a non-encodable value.
  always_comb begin
    chk_err_s = 1'b0;
    case (bus.i_fmt)
      I_TYPE, S_TYPE: chk_err_s = !fits_signed(imm_s, 32'd12);
      B_TYPE:         chk_err_s = !fits_signed(imm_s, 32'd13) || imm_s[0];
      J_TYPE:         chk_err_s = !fits_signed(imm_s, 32'd21) || imm_s[0];
      U_TYPE:         chk_err_s = !fits_signed(imm_s, 32'd32) || (imm_s[11:0] != 12'd0);
      FMT_LI:         chk_err_s = !fits_signed(imm_s, 32'd32);
      default:        chk_err_s = 1'b0;
    endcase
  end
`else
  logic unused_imm_s;
  assign unused_imm_s = ^imm_s[63:32];
  assign chk_err_s    = 1'b0;
`endif

  // Word packing and li expansion decision.
  always_comb begin
    word_s = 32'd0;
    pend_s = 32'd0;
    two_s  = 1'b0;
    case (bus.i_fmt)
      I_TYPE: word_s = {imm_s[11:0], bus.i_rs1, bus.i_funct3, bus.i_rd, bus.i_opcode};
      S_TYPE: word_s = {imm_s[11:5], bus.i_rs2, bus.i_rs1, bus.i_funct3, imm_s[4:0], bus.i_opcode};
      B_TYPE: word_s = {imm_s[12], imm_s[10:5], bus.i_rs2, bus.i_rs1, bus.i_funct3,
                        imm_s[4:1], imm_s[11], bus.i_opcode};
      U_TYPE: word_s = {imm_s[31:12], bus.i_rd, bus.i_opcode};
      J_TYPE: word_s = {imm_s[20], imm_s[10:1], imm_s[11], imm_s[19:12], bus.i_rd, bus.i_opcode};
      FMT_LI: begin
        // An out-of-range li always produces the full pair so both halves flag o_err.
        if (chk_err_s || ((li_hi_s != 20'd0) && (li_lo_s != 12'd0))) begin
          word_s = {li_hi_s, bus.i_rd, OP_LUI};
          pend_s = {li_lo_s, bus.i_rd, 3'b000, bus.i_rd, OP_IMM32};
          two_s  = 1'b1;
        end else if (li_hi_s == 20'd0) begin
          word_s = {li_lo_s, 5'd0, 3'b000, bus.i_rd, OP_IMM};
        end else begin
          word_s = {li_hi_s, bus.i_rd, OP_LUI};
        end
      end
      default: word_s = 32'd0;
    endcase
  end

  assign ready_s  = (state_r == S_IDLE) && (!valid_r || bus.i_ready);
  assign accept_s = bus.i_valid && ready_s;

  // Output register and li second-word sequencing.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r      <= S_IDLE;
      valid_r      <= 1'b0;
      instr_r      <= 32'd0;
      last_r       <= 1'b0;
      err_r        <= 1'b0;
      pend_instr_r <= 32'd0;
      pend_err_r   <= 1'b0;
    end else begin
      case (state_r)
        S_LI_LO: begin
          if (bus.i_ready) begin
            instr_r <= pend_instr_r;
            last_r  <= 1'b1;
            err_r   <= pend_err_r;
            state_r <= S_IDLE;
          end else begin
            state_r <= S_LI_LO;
          end
        end
        S_IDLE: begin
          if (accept_s) begin
            valid_r <= 1'b1;
            instr_r <= word_s;
            last_r  <= !two_s;
            err_r   <= chk_err_s;
            if (two_s) begin
              pend_instr_r <= pend_s;
              pend_err_r   <= chk_err_s;
              state_r      <= S_LI_LO;
            end else begin
              state_r <= S_IDLE;
            end
          end else if (bus.i_ready) begin
            valid_r <= 1'b0;
          end else begin
            valid_r <= valid_r;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign bus.o_ready = ready_s;
  assign bus.o_valid = valid_r;
  assign bus.o_instr = instr_r;
  assign bus.o_last  = last_r;
  assign bus.o_err   = err_r;

endmodule
